// File: rtl/muldiv_unit_param.sv
// Multiply/divide unit with a valid/ready handshake on both sides.
// The multiply path is a pipelined full-width product; the divide path is radix-4 restoring.
module muldiv_unit_param #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_src0,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [1:0]       in_op,
  input  logic             in_sign,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res0,
  output logic [WIDTH-1:0] out_res1,
  output logic [1:0]       out_op,
  output logic             out_dz
);
  // state | meaning
  // IDLE  | waiting for a request, in_ready = 1
  // MUL   | product moving through the multiply pipeline
  // DIV   | radix-4 iteration, or one-cycle bypass for divide-by-zero / overflow
  // DONE  | result presented, held until out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic               sign_q, neg_q, neg_r, dz_q, ovf_q;
  logic [WIDTH-1:0]   op_a, op_b, div_q, div_r;
  logic [2*WIDTH-1:0] ext_a, ext_b, mul_prod, mul_tail;

  logic [WIDTH-1:0]   abs_a, abs_b, q_fix, r_fix, r_nx;
  logic [WIDTH+1:0]   r_sh, d1, d2, d3;
  logic [1:0]         digit;
  logic               is_dz, is_ovf;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Sign-extending both operands to 2*WIDTH makes one truncated multiply serve signed and unsigned.
  always_comb begin
    ext_a    = {{WIDTH{sign_q & op_a[WIDTH-1]}}, op_a};
    ext_b    = {{WIDTH{sign_q & op_b[WIDTH-1]}}, op_b};
    mul_prod = ext_a * ext_b;
  end

  generate
    if (MUL_LATENCY == 1) begin : g_mul_direct
      assign mul_tail = mul_prod;
    end else begin : g_mul_pipe
      logic [2*WIDTH-1:0] pipe [MUL_LATENCY-1];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < MUL_LATENCY - 1; i++) pipe[i] <= '0;
        end else if (state == S_MUL) begin
          pipe[0] <= mul_prod;
          for (int i = 1; i < MUL_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign mul_tail = pipe[MUL_LATENCY-2];
    end
  endgenerate

  always_comb begin
    abs_a  = (in_sign & in_src0[WIDTH-1]) ? -in_src0 : in_src0;
    abs_b  = (in_sign & in_src1[WIDTH-1]) ? -in_src1 : in_src1;
    is_dz  = (in_src1 == '0);
    is_ovf = in_sign && (in_src0 == MOST_NEG) && (in_src1 == '1);
  end

  // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+2 bits.
  always_comb begin
    r_sh = {div_r, div_q[WIDTH-1 -: 2]};
    d1   = {2'b00, op_b};
    d2   = {1'b0, op_b, 1'b0};
    d3   = d1 + d2;
    if (r_sh >= d3) begin
      digit = 2'd3;
      r_nx  = WIDTH'(r_sh - d3);
    end else if (r_sh >= d2) begin
      digit = 2'd2;
      r_nx  = WIDTH'(r_sh - d2);
    end else if (r_sh >= d1) begin
      digit = 2'd1;
      r_nx  = WIDTH'(r_sh - d1);
    end else begin
      digit = 2'd0;
      r_nx  = WIDTH'(r_sh);
    end
    q_fix = neg_q ? -div_q : div_q;
    r_fix = neg_r ? -div_r : div_r;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      div_q    <= '0;
      div_r    <= '0;
      out_res0 <= '0;
      out_res1 <= '0;
      out_op   <= '0;
      out_dz   <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && (in_op == OP_MUL || in_op == OP_DIV)) begin
            op_q   <= in_op;
            sign_q <= in_sign;
            op_a   <= in_src0;
            if (in_op == OP_MUL) begin
              op_b  <= in_src1;
              cnt   <= CW'(MUL_LATENCY - 1);
              state <= S_MUL;
            end else begin
              op_b  <= abs_b;
              div_q <= abs_a;
              div_r <= '0;
              neg_q <= in_sign & (in_src0[WIDTH-1] ^ in_src1[WIDTH-1]);
              neg_r <= in_sign & in_src0[WIDTH-1];
              dz_q  <= is_dz;
              ovf_q <= is_ovf;
              cnt   <= (is_dz || is_ovf) ? '0 : CW'(WIDTH / 2);
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            {out_res1, out_res0} <= mul_tail;
            out_op <= op_q;
            out_dz <= 1'b0;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (cnt != '0) begin
            div_r <= r_nx;
            div_q <= {div_q[WIDTH-3:0], digit};
            cnt   <= cnt - 1'b1;
          end else begin
            if (dz_q) begin
              out_res0 <= '1;
              out_res1 <= op_a;
            end else if (ovf_q) begin
              out_res0 <= MOST_NEG;
              out_res1 <= '0;
            end else begin
              out_res0 <= q_fix;
              out_res1 <= r_fix;
            end
            out_dz <= dz_q;
            out_op <= op_q;
            state  <= S_DONE;
          end
        end
        default: begin
          if (out_ready) state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
